spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 36 +++
 rtl/spi_slave.sv | 152 +++++++++++++++
 tb/tb_spi_slave.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI slave bus and byte handshake bundle.
// o_overrun is present only when SPI_SLAVE_OVERRUN_EN is defined.
interface spi_slave_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_SCLK;
  logic                  i_SS;
  logic                  i_MOSI;
  logic                  o_MISO;
  logic [DATA_WIDTH-1:0] i_data_in_TX;
  logic                  i_data_valid_TX;
  logic                  o_data_ready_TX;
  logic [DATA_WIDTH-1:0] o_data_out;
  logic                  o_data_valid;
  logic                  i_data_ready;
  logic                  o_busy;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                  o_overrun;
`endif

  modport slave (
    input  i_SCLK, i_SS, i_MOSI, i_data_in_TX, i_data_valid_TX, i_data_ready,
    output o_MISO, o_data_ready_TX, o_data_out, o_data_valid, o_busy
`ifdef SPI_SLAVE_OVERRUN_EN
    , output o_overrun
`endif
  );

  modport master (
    output i_SCLK, i_SS, i_MOSI, i_data_in_TX, i_data_valid_TX, i_data_ready,
    input  o_MISO, o_data_ready_TX, o_data_out, o_data_valid, o_busy
`ifdef SPI_SLAVE_OVERRUN_EN
    , input o_overrun
`endif
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, LSB first, oversampled by clk with 2-flop pin synchronizers.
// Define SPI_SLAVE_OVERRUN_EN to add the sticky o_overrun flag.
module spi_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '0
) (
  input  logic       clk,
  input  logic       reset,
  spi_slave_if.slave bus
);
  localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;

  logic [2:0] sclk_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;
  logic       sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;

  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next, hold, data_out;
  logic                  hold_valid, data_valid;
  logic [CW-1:0]         bit_cnt;
  logic                  do_load, do_rx, do_tx, frame_done, tx_accept;

  // Flops [0],[1] synchronize; edges compare [1] against [2].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q <= '0;
      mosi_q <= '0;
      ss_q   <= '1;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.i_SCLK};
      mosi_q <= {mosi_q[0], bus.i_MOSI};
      ss_q   <= {ss_q[1:0], bus.i_SS};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign mosi_s    = mosi_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_rx      = 1'b0;
    do_tx      = 1'b0;
    frame_done = 1'b0;
    if (ss_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (ss_fall) state_nxt = LOAD;
        LOAD: begin
          do_load   = 1'b1;
          state_nxt = SHIFT;
        end
        SHIFT: begin
          if (sclk_rise) begin
            do_rx = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              frame_done = 1'b1;
              state_nxt  = LOAD;
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            // bit_cnt is 0 only before the first rise or after the wrap,
            // so the trailing fall of a frame never advances MISO.
            do_tx = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_next          = rx_shift;
    rx_next[bit_cnt] = mosi_s;
  end

  assign tx_accept = bus.i_data_valid_TX & ~hold_valid;

  // Holding register: a write landing on the LOAD edge wins over the clear,
  // so that byte waits for the following frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (do_load) hold_valid <= 1'b0;
      if (tx_accept) begin
        hold       <= bus.i_data_in_TX;
        hold_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      if (do_load) begin
        tx_shift <= hold_valid ? hold : TX_IDLE;
        bit_cnt  <= '0;
      end
      if (do_tx) tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
      if (do_rx) begin
        rx_shift <= rx_next;
        bit_cnt  <= frame_done ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (frame_done) begin
      data_out   <= rx_next;
      data_valid <= 1'b1;
    end else if (bus.i_data_ready) begin
      data_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                 overrun <= 1'b0;
    else if (frame_done && data_valid && !bus.i_data_ready) overrun <= 1'b1;
  end

  assign bus.o_overrun = overrun;
`endif

  assign bus.o_MISO          = (state != IDLE) & ~ss_q[1] & tx_shift[0];
  assign bus.o_data_ready_TX = ~hold_valid;
  assign bus.o_data_out      = data_out;
  assign bus.o_data_valid    = data_valid;
  assign bus.o_busy          = (state != IDLE);
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: SPI master at clk/8 with hand-computed frames.
module tb_spi_slave;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(8)) bus ();

  spi_slave #(.DATA_WIDTH(8), .TX_IDLE(8'h00)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int drop_cnt = 0;
  int base;
  logic [7:0] m, m1, m2;

  always @(negedge clk) begin
    if (bus.o_data_valid)     vcnt     <= vcnt + 1;
    if (!bus.o_data_ready_TX) drop_cnt <= drop_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    bus.i_data_in_TX    = d;
    bus.i_data_valid_TX = 1'b1;
    tick(1);
    bus.i_data_valid_TX = 1'b0;
  endtask

  task automatic ss_low();
    bus.i_SS = 1'b0;
    tick(6);
  endtask

  task automatic ss_high();
    bus.i_SS = 1'b1;
    tick(6);
  endtask

  // Mode 0: MOSI set while SCLK low, MISO captured just before each rise.
  task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.i_MOSI = mosi[i];
      tick(4);
      miso[i]    = bus.o_MISO;
      bus.i_SCLK = 1'b1;
      tick(4);
      bus.i_SCLK = 1'b0;
    end
  endtask

  initial begin
    reset               = 1'b0;
    bus.i_SCLK          = 1'b0;
    bus.i_SS            = 1'b1;
    bus.i_MOSI          = 1'b0;
    bus.i_data_in_TX    = '0;
    bus.i_data_valid_TX = 1'b0;
    bus.i_data_ready    = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);

    check("rst_miso", bus.o_MISO, 0);
    check("rst_data_out", bus.o_data_out, 0);
    check("rst_valid", bus.o_data_valid, 0);
    check("rst_ready_tx", bus.o_data_ready_TX, 1);
    check("rst_busy", bus.o_busy, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("rst_overrun", bus.o_overrun, 0);
`endif

    // Preloaded 0x5A out, 0xC3 in, consumer always ready.
    bus.i_data_ready = 1'b1;
    tx_write(8'h5A);
    check("tx_full", bus.o_data_ready_TX, 0);
    base = vcnt;
    ss_low();
    check("busy_in_frame", bus.o_busy, 1);
    spi_bits(8'hC3, 8, m);
    tick(2);
    check("miso_5a", m, 8'h5A);
    check("rx_c3", bus.o_data_out, 8'hC3);
    check("valid_one_cycle", vcnt - base, 1);
    check("tx_drained", bus.o_data_ready_TX, 1);
    ss_high();
    check("idle_busy", bus.o_busy, 0);
    check("idle_miso", bus.o_MISO, 0);

    // No preload: idle pattern on MISO, holding register never fills.
    bus.i_data_ready = 1'b0;
    base = drop_cnt;
    ss_low();
    spi_bits(8'h01, 8, m);
    tick(2);
    check("miso_idle", m, 8'h00);
    check("rx_01", bus.o_data_out, 8'h01);
    check("valid_held", bus.o_data_valid, 1);
    check("ready_tx_stays", drop_cnt - base, 0);
    ss_high();
    bus.i_data_ready = 1'b1;
    tick(1);
    check("valid_accepted", bus.o_data_valid, 0);

    // Back-to-back frames under one SS low, second TX byte written mid-frame.
    tx_write(8'h11);
    ss_low();
    tx_write(8'h22);
    spi_bits(8'hA5, 8, m1);
    check("rx_a5", bus.o_data_out, 8'hA5);
    spi_bits(8'h3C, 8, m2);
    tick(2);
    check("rx_3c", bus.o_data_out, 8'h3C);
    check("miso_11", m1, 8'h11);
    check("miso_22", m2, 8'h22);
    ss_high();

    // Abort after 4 bits: no frame, pending TX byte survives for the next one.
    base = vcnt;
    ss_low();
    tx_write(8'h77);
    spi_bits(8'h0F, 4, m);
    bus.i_SS = 1'b1;
    tick(8);
    check("abort_no_valid", vcnt - base, 0);
    check("abort_idle", bus.o_busy, 0);
    check("abort_tx_kept", bus.o_data_ready_TX, 0);
    ss_low();
    spi_bits(8'hFF, 8, m);
    tick(2);
    check("rx_ff", bus.o_data_out, 8'hFF);
    check("miso_77", m, 8'h77);
    check("valid_after_abort", vcnt - base, 1);
    ss_high();

    // Two frames with the consumer stalled: second overwrites the first.
    bus.i_data_ready = 1'b0;
    ss_low();
    spi_bits(8'h12, 8, m);
    tick(2);
    check("rx_12", bus.o_data_out, 8'h12);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("no_overrun_yet", bus.o_overrun, 0);
`endif
    spi_bits(8'h34, 8, m);
    tick(2);
    ss_high();
    check("rx_overwrite_34", bus.o_data_out, 8'h34);
    check("valid_stalled", bus.o_data_valid, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("overrun_set", bus.o_overrun, 1);
`endif

    // Reset at bit 5 with a byte pending: outputs clear without a clock edge.
    ss_low();
    tx_write(8'h99);
    spi_bits(8'hAA, 5, m);
    check("pre_rst_busy", bus.o_busy, 1);
    check("pre_rst_tx_full", bus.o_data_ready_TX, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_miso", bus.o_MISO, 0);
    check("mid_rst_data_out", bus.o_data_out, 0);
    check("mid_rst_valid", bus.o_data_valid, 0);
    check("mid_rst_ready_tx", bus.o_data_ready_TX, 1);
    check("mid_rst_busy", bus.o_busy, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("mid_rst_overrun", bus.o_overrun, 0);
`endif
    bus.i_SS = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(4);
    check("post_rst_busy", bus.o_busy, 0);
    check("post_rst_valid", bus.o_data_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
